// File: rtl/tmr_fault_pkg.sv
// Shared types and constants for the TMR fault manager.
package tmr_fault_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        RESYNC = 1'b1
    } state_t;

    typedef logic [1:0] replica_t;

    localparam replica_t REPLICA_A = 2'd0;
    localparam replica_t REPLICA_B = 2'd1;
    localparam replica_t REPLICA_C = 2'd2;

    localparam int unsigned CORR_CNT_W = 16;

    // Lowest replica index whose flag is set (A wins ties); defaults to C.
    function automatic replica_t lowest_set(input logic [2:0] v);
        if (v[0])      return REPLICA_A;
        else if (v[1]) return REPLICA_B;
        else           return REPLICA_C;
    endfunction

endpackage

// File: rtl/tmr_word_vote.sv
// Combinational 2-of-3 bitwise voter with per-replica mismatch flags.
module tmr_word_vote #(
    parameter int unsigned DataWidth = 32
) (
    input  logic [DataWidth-1:0] data_a,
    input  logic [DataWidth-1:0] data_b,
    input  logic [DataWidth-1:0] data_c,
    output logic [DataWidth-1:0] voted,
    output logic [2:0]           mismatch
);

    assign voted    = (data_a & data_b) | (data_a & data_c) | (data_b & data_c);
    assign mismatch = {|(data_c ^ voted), |(data_b ^ voted), |(data_a ^ voted)};

endmodule

// File: rtl/tmr_fault_manager.sv
// TMR fault manager: votes three replica words, tracks consecutive
// mismatches per replica and requests a resync of a replica that keeps
// disagreeing. Optional per-replica correction counters are enabled with
// the TMR_FAULT_MANAGER_CORR_CNT_EN macro.
module tmr_fault_manager
    import tmr_fault_pkg::*;
#(
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned FaultThreshold = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [DataWidth-1:0]          data_a_i,
    input  logic [DataWidth-1:0]          data_b_i,
    input  logic [DataWidth-1:0]          data_c_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic [DataWidth-1:0]          data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [2:0]                    fault_o,
    output logic                          uncorrectable_o,
    output logic                          resync_req_o,
    output logic [1:0]                    resync_id_o,
    input  logic                          resync_ack_i,
    output logic [2:0][CORR_CNT_W-1:0]    corr_cnt_o
);

    // Threshold fits in 8 bits (legal range 1..255).
    localparam int unsigned      CntW = 8;
    localparam logic [CntW-1:0]  Thr  = CntW'(FaultThreshold);

`ifndef TARGET_SYNTHESIS
    if (FaultThreshold == 0 || FaultThreshold > 255 || DataWidth == 0) begin : g_param_check
        $fatal(1, "tmr_fault_manager: illegal DataWidth/FaultThreshold");
    end
`endif

    state_t                 state;
    logic [2:0][CntW-1:0]   cnt;
    logic [2:0][CntW-1:0]   cnt_nxt;
    logic [2:0]             hit;
    logic [DataWidth-1:0]   voted;
    logic [2:0]             mismatch;
    logic                   accept;
    logic                   uncorr;

    tmr_word_vote #(.DataWidth(DataWidth)) u_vote (
        .data_a   (data_a_i),
        .data_b   (data_b_i),
        .data_c   (data_c_i),
        .voted    (voted),
        .mismatch (mismatch)
    );

    assign ready_o = (state == RUN) && (!valid_o || ready_i);
    assign accept  = valid_i && ready_o;
    assign uncorr  = (mismatch[0] & mismatch[1]) | (mismatch[0] & mismatch[2]) |
                     (mismatch[1] & mismatch[2]);

    // Next consecutive-mismatch counts for an accepted beat, saturating at threshold.
    always_comb begin
        cnt_nxt = '0;
        hit     = '0;
        for (int k = 0; k < 3; k++) begin
            if (mismatch[k])
                cnt_nxt[k] = (cnt[k] >= Thr) ? Thr : cnt[k] + 8'd1;
            else
                cnt_nxt[k] = '0;
            hit[k] = (cnt_nxt[k] == Thr);
        end
    end

    // Output stage: one-cycle latency, holds under backpressure, drains in RESYNC.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o         <= 1'b0;
            data_o          <= '0;
            fault_o         <= '0;
            uncorrectable_o <= 1'b0;
        end else if (accept) begin
            valid_o         <= 1'b1;
            data_o          <= voted;
            fault_o         <= mismatch;
            uncorrectable_o <= uncorr;
        end else if (valid_o && ready_i) begin
            valid_o         <= 1'b0;
        end
    end

    // Resync FSM with registered request outputs; owns the mismatch counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= RUN;
            cnt          <= '0;
            resync_req_o <= 1'b0;
            resync_id_o  <= REPLICA_A;
        end else begin
            case (state)
                RUN: begin
                    if (accept) begin
                        cnt <= cnt_nxt;
                        if (|hit) begin
                            state        <= RESYNC;
                            resync_req_o <= 1'b1;
                            resync_id_o  <= lowest_set(hit);
                        end
                    end
                end
                RESYNC: begin
                    if (resync_ack_i) begin
                        cnt[resync_id_o] <= '0;
                        state            <= RUN;
                        resync_req_o     <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef TMR_FAULT_MANAGER_CORR_CNT_EN
    // Lifetime correction counters, saturating at all-ones.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            corr_cnt_o <= '0;
        end else if (accept) begin
            for (int k = 0; k < 3; k++) begin
                if (mismatch[k] && corr_cnt_o[k] != '1)
                    corr_cnt_o[k] <= corr_cnt_o[k] + 16'd1;
            end
        end
    end
`else
    assign corr_cnt_o = '0;
`endif

endmodule
